// File: rtl/half_sub_pkg.sv
// half_sub_pkg: default sizing constants shared by the half subtractor files
package half_sub_pkg;
  localparam int HALF_SUB_WIDTH = 1;
  localparam int HALF_SUB_CNT_W = 8;
  localparam logic [HALF_SUB_CNT_W-1:0] HALF_SUB_CNT_MAX = '1;
endpackage

// File: rtl/half_sub_bit.sv
// half_sub_bit: one combinational half-subtractor lane
module half_sub_bit (
  input  logic a_i,
  input  logic b_i,
  output logic diff_o,
  output logic borr_o
);
  assign diff_o = a_i ^ b_i;
  assign borr_o = ~a_i & b_i;
endmodule

// File: rtl/half_sub.sv
// half_sub: per-lane half subtractor with registered copy and saturating borrow counter
module half_sub
  import half_sub_pkg::*;
#(
  parameter int WIDTH = HALF_SUB_WIDTH,
  parameter int CNT_W = HALF_SUB_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic [WIDTH-1:0] borr,
  output logic [WIDTH-1:0] diff_q,
  output logic [WIDTH-1:0] borr_q,
  output logic [CNT_W-1:0] borr_cnt
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic [WIDTH-1:0] diff_d, borr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_sub_bit u_bit (.a_i(a[i]), .b_i(b[i]), .diff_o(diff[i]), .borr_o(borr[i]));
  end
  // next state: reset clears, otherwise capture lanes and count borrow cycles up to saturation
  always_comb begin
    diff_d = rst ? '0 : diff;
    borr_d = rst ? '0 : borr;
    cnt_d  = rst ? '0 : (|borr && cnt_q != CNT_MAX) ? cnt_q + 1'b1 : cnt_q;
  end
  // state registers
  always_ff @(posedge clk) begin
    diff_q <= diff_d;
    borr_q <= borr_d;
    cnt_q  <= cnt_d;
  end
  assign borr_cnt = cnt_q;
endmodule

// File: tb/tb_half_sub.sv
// tb_half_sub: directed self-checking bench for half_sub
module tb_half_sub;
  logic clk = 1'b0, clk_en = 1'b0, rst = 1'b0, rst_s = 1'b0;
  logic a1 = 1'b0, b1 = 1'b0, d1, br1, dq1, bq1;
  logic [7:0] c1;
  logic as_ = 1'b0, bs = 1'b0, ds, brs, dqs, bqs;
  logic [1:0] cs;
  logic [3:0] a4 = '0, b4 = '0, d4, br4, dq4, bq4;
  logic [7:0] c4;
  int checks = 0, errors = 0;

  half_sub u1 (.clk(clk), .rst(rst), .a(a1), .b(b1), .diff(d1), .borr(br1),
               .diff_q(dq1), .borr_q(bq1), .borr_cnt(c1));
  half_sub #(.WIDTH(1), .CNT_W(2)) us (.clk(clk), .rst(rst_s), .a(as_), .b(bs), .diff(ds), .borr(brs),
               .diff_q(dqs), .borr_q(bqs), .borr_cnt(cs));
  half_sub #(.WIDTH(4), .CNT_W(8)) u4 (.clk(clk), .rst(rst), .a(a4), .b(b4), .diff(d4), .borr(br4),
               .diff_q(dq4), .borr_q(bq4), .borr_cnt(c4));

  always #5 if (clk_en) clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a1 = 0; b1 = 0; #5; chk("tt00", {d1, br1}, 2'b00);
    a1 = 0; b1 = 1; #5; chk("tt01", {d1, br1}, 2'b11);
    a1 = 1; b1 = 0; #5; chk("tt10", {d1, br1}, 2'b10);
    a1 = 1; b1 = 1; #5; chk("tt11", {d1, br1}, 2'b00);
    a4 = 4'b1010; b4 = 4'b0110; #5;
    chk("w4_diff", d4, 4'b1100);
    chk("w4_borr", br4, 4'b0100);
    rst = 1; rst_s = 1; a1 = 0; b1 = 1; as_ = 0; bs = 1;
    clk_en = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rstpri_dq", dq1, 1'b0);
      chk("rstpri_bq", bq1, 1'b0);
      chk("rstpri_cnt", c1, 8'd0);
      chk("rstpri_comb", {d1, br1}, 2'b11);
    end
    chk("rst_sat_cnt", cs, 2'd0);
    chk("rst_w4_dq", dq4, 4'd0);
    chk("rst_w4_cnt", c4, 8'd0);
    rst = 0; rst_s = 0;
    #2;
    chk("pre_edge_dq", {dq1, bq1}, 2'b00);
    step();
    chk("reg_dq", {dq1, bq1}, 2'b11);
    chk("w4_dq", dq4, 4'b1100);
    chk("w4_bq", bq4, 4'b0100);
    chk("w4_cnt", c4, 8'd1);
    a4 = 4'b1111; b4 = 4'b0000;
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) step();
      chk("cnt_u1", c1, k);
      chk("cnt_sat", cs, k <= 3 ? k : 3);
    end
    chk("w4_hold_cnt", c4, 8'd1);
    chk("w4_dq2", dq4, 4'b1111);
    rst = 1;
    step();
    chk("mid_rst_cnt", c1, 8'd0);
    chk("mid_rst_dq", {dq1, bq1}, 2'b00);
    chk("sat6", cs, 2'd3);
    rst = 0;
    step();
    chk("resume_cnt", c1, 8'd1);
    chk("resume_dq", {dq1, bq1}, 2'b11);
    a1 = 1; b1 = 1; as_ = 1; bs = 1;
    step();
    chk("sat_hold", cs, 2'd3);
    chk("u1_hold", c1, 8'd1);
    chk("u1_11_q", {dq1, bq1}, 2'b00);
    a1 = 1; b1 = 0;
    step();
    chk("u1_10_q", {dq1, bq1}, 2'b10);
    chk("u1_10_cnt", c1, 8'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
